// File: rtl/emib_ch_s2m_dly.sv
// EMIB channel model, slave-to-master direction.
// Carries words from the slave AIB to the master AIB through a configurable
// delay line of 1..MAX_DLY cycles. Adjacent lane pairs are swapped, and a
// single-bit error can be injected into one word.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   s_tx_data/vld   word from the slave AIB (vld=0 enters a bubble)
//   cfg_dly         requested latency minus 1; sampled only while idle
//   flush           drop every in-flight word
//   inj_en/lane     arm a one-bit flip on the next accepted word
//   m_rx_data/vld   delayed, remapped word toward the master AIB
//   dly_busy        at least one valid word in flight
//   inj_pend        flip armed, not yet applied
//   inj_bad         sticky: injection requested on a lane that does not exist
//   word_cnt        saturating count of delivered words
//   inj_cnt         saturating count of applied flips
module emib_ch_s2m_dly #(
    parameter int unsigned DWIDTH  = 40,
    parameter int unsigned MAX_DLY = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DWIDTH-1:0] s_tx_data,
    input  logic              s_tx_vld,
    input  logic [2:0]        cfg_dly,
    input  logic              flush,
    input  logic              inj_en,
    input  logic [5:0]        inj_lane,
    output logic [DWIDTH-1:0] m_rx_data,
    output logic              m_rx_vld,
    output logic              dly_busy,
    output logic              inj_pend,
    output logic              inj_bad,
    output logic [15:0]       word_cnt,
    output logic [7:0]        inj_cnt
);

    // m_rx_* is the last stage of the delay line, so only MAX_DLY-1 internal
    // stages are needed ahead of it.
    localparam int unsigned NSTG    = (MAX_DLY > 1) ? MAX_DLY - 1 : 1;
    localparam logic [2:0]  DLY_MAX = 3'(MAX_DLY - 1);
    localparam logic [6:0]  LANES   = 7'(DWIDTH);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;

    logic [DWIDTH-1:0] stg_data [NSTG];
    logic [NSTG-1:0]   stg_vld;
    logic [NSTG-1:0]   stg_vld_nxt;
    logic [2:0]        cur_dly;
    logic [2:0]        cfg_lim;
    logic [2:0]        tap_idx;
    logic [5:0]        pend_lane;
    logic [5:0]        flip_lane;
    logic              lane_ok;
    logic              acc_vld;
    logic              do_flip;
    logic              arm;
    logic              out_vld_nxt;
    logic              dly_ld;
    logic [DWIDTH-1:0] flip_mask;
    logic [DWIDTH-1:0] in_word;
    logic [DWIDTH-1:0] in_remap;
    logic [DWIDTH-1:0] out_data_src;

    // Input path: error injection, then pairwise lane swap.
    always_comb begin
        lane_ok   = {1'b0, inj_lane} < LANES;
        acc_vld   = s_tx_vld & ~flush;
        // An armed injection keeps its captured lane; a new request is ignored.
        flip_lane = inj_pend ? pend_lane : inj_lane;
        do_flip   = acc_vld & (inj_pend | (inj_en & lane_ok));
        arm       = inj_en & lane_ok & ~inj_pend & ~do_flip;
        flip_mask = do_flip ? (DWIDTH'(1) << flip_lane) : '0;
        in_word   = s_tx_data ^ flip_mask;
        in_remap  = '0;
        for (int k = 0; k < int'(DWIDTH / 2); k++) begin
            in_remap[2*k]   = in_word[2*k+1];
            in_remap[2*k+1] = in_word[2*k];
        end
    end

    // Delay line next state; valid bits at or beyond the tap are dropped so
    // a later, longer tap never exposes words that were already delivered.
    always_comb begin
        tap_idx        = cur_dly - 3'd1;
        stg_vld_nxt    = '0;
        stg_vld_nxt[0] = ~flush & acc_vld & (cur_dly != 3'd0);
        for (int k = 1; k < int'(NSTG); k++) begin
            stg_vld_nxt[k] = ~flush & stg_vld[k-1] & (k < int'(cur_dly));
        end
        out_vld_nxt  = ~flush & ((cur_dly == 3'd0) ? acc_vld : stg_vld[tap_idx]);
        out_data_src = (cur_dly == 3'd0) ? in_remap : stg_data[tap_idx];
        cfg_lim      = (cfg_dly > DLY_MAX) ? DLY_MAX : cfg_dly;
        dly_ld       = (state == IDLE) & ~s_tx_vld;
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state: RUN while any valid word sits up to and including the tap.
    always_comb begin
        state_nxt = IDLE;
        if (out_vld_nxt || (|stg_vld_nxt)) begin
            state_nxt = RUN;
        end
    end

    // FSM outputs.
    always_comb begin
        dly_busy = (state == RUN);
    end

    // Delay line, output stage and active latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            stg_vld   <= '0;
            m_rx_vld  <= 1'b0;
            m_rx_data <= '0;
            cur_dly   <= cfg_lim;
            for (int k = 0; k < int'(NSTG); k++) begin
                stg_data[k] <= '0;
            end
        end else begin
            stg_vld  <= stg_vld_nxt;
            m_rx_vld <= out_vld_nxt;
            if (out_vld_nxt) begin
                m_rx_data <= out_data_src;
            end
            // Flush only kills valid bits; stage data is left untouched.
            if (!flush) begin
                stg_data[0] <= in_remap;
                for (int k = 1; k < int'(NSTG); k++) begin
                    stg_data[k] <= stg_data[k-1];
                end
            end
            if (dly_ld) begin
                cur_dly <= cfg_lim;
            end
        end
    end

    // Injection control and statistics.
    always_ff @(posedge clk) begin
        if (rst) begin
            inj_pend  <= 1'b0;
            pend_lane <= '0;
            inj_bad   <= 1'b0;
            word_cnt  <= '0;
            inj_cnt   <= '0;
        end else begin
            if (inj_en && !lane_ok) begin
                inj_bad <= 1'b1;
            end
            if (do_flip) begin
                inj_pend <= 1'b0;
            end else if (arm) begin
                inj_pend  <= 1'b1;
                pend_lane <= inj_lane;
            end
            if (do_flip && (inj_cnt != 8'hFF)) begin
                inj_cnt <= inj_cnt + 8'd1;
            end
            if (out_vld_nxt && (word_cnt != 16'hFFFF)) begin
                word_cnt <= word_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_emib_ch_s2m_dly.sv
// Scoreboard bench for emib_ch_s2m_dly (DWIDTH=40, MAX_DLY=8).
// Stimulus pushes the hand-computed word and its arrival cycle; a monitor
// pops and compares whenever m_rx_vld is seen.
module tb_emib_ch_s2m_dly;

    localparam int unsigned DW = 40;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] s_tx_data;
    logic          s_tx_vld;
    logic [2:0]    cfg_dly;
    logic          flush;
    logic          inj_en;
    logic [5:0]    inj_lane;
    logic [DW-1:0] m_rx_data;
    logic          m_rx_vld;
    logic          dly_busy;
    logic          inj_pend;
    logic          inj_bad;
    logic [15:0]   word_cnt;
    logic [7:0]    inj_cnt;

    emib_ch_s2m_dly #(.DWIDTH(DW), .MAX_DLY(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .s_tx_data (s_tx_data),
        .s_tx_vld  (s_tx_vld),
        .cfg_dly   (cfg_dly),
        .flush     (flush),
        .inj_en    (inj_en),
        .inj_lane  (inj_lane),
        .m_rx_data (m_rx_data),
        .m_rx_vld  (m_rx_vld),
        .dly_busy  (dly_busy),
        .inj_pend  (inj_pend),
        .inj_bad   (inj_bad),
        .word_cnt  (word_cnt),
        .inj_cnt   (inj_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [DW-1:0] data;
        int            at;
    } exp_t;

    exp_t          sb[$];
    exp_t          mon_e;
    int            n_pass   = 0;
    int            n_tot    = 0;
    int            exp_wcnt = 0;
    int            saved_wc;

    // Hand-computed pair-swapped vectors.
    logic [DW-1:0] vin  [5];
    logic [DW-1:0] vexp [5];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    // Monitor: every delivered word must match the oldest expectation.
    always @(negedge clk) begin
        if (m_rx_vld === 1'b1) begin
            if (sb.size() == 0) begin
                n_tot++;
                $display("FAIL unexpected_rx: got data %0h at cycle %0d, want no word", m_rx_data, cyc);
            end else begin
                mon_e = sb.pop_front();
                chk("rx_data", 64'(m_rx_data), 64'(mon_e.data));
                chk("rx_cycle", 64'(cyc), 64'(mon_e.at));
                exp_wcnt++;
                chk("rx_word_cnt", 64'(word_cnt), 64'(exp_wcnt));
            end
        end
    end

    task automatic drive(input logic v, input logic [DW-1:0] d, input logic [DW-1:0] e,
                         input int lat, input logic track, input logic ie, input logic [5:0] il);
        @(negedge clk);
        #1;
        s_tx_vld  = v;
        s_tx_data = d;
        inj_en    = ie;
        inj_lane  = il;
        flush     = 1'b0;
        if (v && track) sb.push_back('{data: e, at: cyc + lat});
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
            s_tx_vld = 1'b0;
            inj_en   = 1'b0;
            flush    = 1'b0;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1);
    end

    initial begin
        vin[0] = 40'h00_0000_0001; vexp[0] = 40'h00_0000_0002;
        vin[1] = 40'hAA_AAAA_AAAA; vexp[1] = 40'h55_5555_5555;
        vin[2] = 40'h12_3456_789A; vexp[2] = 40'h21_38A9_B465;
        vin[3] = 40'hDE_ADBE_EF01; vexp[3] = 40'hED_5E7D_DF02;
        vin[4] = 40'h80_0000_0000; vexp[4] = 40'h40_0000_0000;

        rst = 1'b1; s_tx_vld = 1'b0; s_tx_data = '0; cfg_dly = 3'd0;
        flush = 1'b0; inj_en = 1'b0; inj_lane = '0;
        repeat (3) @(negedge clk);
        chk("rst_m_rx_vld", 64'(m_rx_vld), 64'd0);
        chk("rst_m_rx_data", 64'(m_rx_data), 64'd0);
        chk("rst_dly_busy", 64'(dly_busy), 64'd0);
        chk("rst_inj_pend", 64'(inj_pend), 64'd0);
        chk("rst_inj_bad", 64'(inj_bad), 64'd0);
        chk("rst_word_cnt", 64'(word_cnt), 64'd0);
        chk("rst_inj_cnt", 64'(inj_cnt), 64'd0);
        #1 rst = 1'b0;
        idle(1);

        // Latency 1: single word, bit 0 lands on lane 1.
        drive(1'b1, 40'h00_0000_0001, 40'h00_0000_0002, 1, 1'b1, 1'b0, 6'd0);
        idle(3);
        chk("l1_word_cnt", 64'(word_cnt), 64'd1);

        // Latency 8: ten back-to-back words, busy until the last one is out.
        cfg_dly = 3'd7;
        idle(2);
        for (int i = 0; i < 10; i++) drive(1'b1, vin[i % 5], vexp[i % 5], 8, 1'b1, 1'b0, 6'd0);
        idle(1);
        chk("l8_busy", 64'(dly_busy), 64'd1);
        for (int i = 0; i < 7; i++) begin
            idle(1);
            chk("l8_busy", 64'(dly_busy), 64'd1);
        end
        idle(1);
        chk("l8_busy_end", 64'(dly_busy), 64'd0);

        // cfg_dly changes while busy take effect only after the pipe drains.
        cfg_dly = 3'd2;
        idle(2);
        drive(1'b1, vin[2], vexp[2], 3, 1'b1, 1'b0, 6'd0);
        cfg_dly = 3'd5;
        drive(1'b1, vin[3], vexp[3], 3, 1'b1, 1'b0, 6'd0);
        idle(6);
        drive(1'b1, vin[1], vexp[1], 6, 1'b1, 1'b0, 6'd0);
        idle(8);

        // Error injection.
        cfg_dly = 3'd1;
        idle(2);
        drive(1'b0, '0, '0, 0, 1'b0, 1'b1, 6'd3);
        idle(1);
        chk("inj_armed", 64'(inj_pend), 64'd1);
        drive(1'b1, '0, 40'h00_0000_0004, 2, 1'b1, 1'b0, 6'd0);
        idle(1);
        chk("inj_cleared", 64'(inj_pend), 64'd0);
        chk("inj_cnt_1", 64'(inj_cnt), 64'd1);
        drive(1'b0, '0, '0, 0, 1'b0, 1'b1, 6'd45);
        idle(1);
        chk("inj_bad_set", 64'(inj_bad), 64'd1);
        chk("inj_bad_noarm", 64'(inj_pend), 64'd0);
        drive(1'b1, '0, '0, 2, 1'b1, 1'b0, 6'd0);
        drive(1'b1, '0, 40'h00_0000_0002, 2, 1'b1, 1'b1, 6'd0);
        idle(1);
        chk("inj_same_nopend", 64'(inj_pend), 64'd0);
        chk("inj_cnt_2", 64'(inj_cnt), 64'd2);
        drive(1'b0, '0, '0, 0, 1'b0, 1'b1, 6'd4);
        drive(1'b0, '0, '0, 0, 1'b0, 1'b1, 6'd6);
        drive(1'b1, '0, 40'h00_0000_0020, 2, 1'b1, 1'b0, 6'd0);
        idle(3);
        chk("inj_cnt_3", 64'(inj_cnt), 64'd3);
        chk("inj_pend_idle", 64'(inj_pend), 64'd0);

        // Flush with three words in flight at latency 5.
        cfg_dly = 3'd4;
        idle(2);
        saved_wc = exp_wcnt;
        for (int i = 0; i < 3; i++) drive(1'b1, vin[i], vexp[i], 5, 1'b0, 1'b0, 6'd0);
        @(negedge clk);
        #1;
        s_tx_vld = 1'b0;
        flush    = 1'b1;
        idle(1);
        chk("flush_busy", 64'(dly_busy), 64'd0);
        idle(10);
        chk("flush_word_cnt", 64'(word_cnt), 64'(saved_wc));
        chk("flush_inj_cnt", 64'(inj_cnt), 64'd3);

        // Reset mid-stream overrides everything on the same edge.
        cfg_dly = 3'd3;
        idle(2);
        for (int i = 0; i < 3; i++) drive(1'b1, vin[i], vexp[i], 4, 1'b0, 1'b0, 6'd0);
        @(negedge clk);
        #1;
        rst = 1'b1; s_tx_vld = 1'b1; s_tx_data = vin[3];
        flush = 1'b1; inj_en = 1'b1; inj_lane = 6'd2;
        @(negedge clk);
        chk("mrst_m_rx_vld", 64'(m_rx_vld), 64'd0);
        chk("mrst_m_rx_data", 64'(m_rx_data), 64'd0);
        chk("mrst_dly_busy", 64'(dly_busy), 64'd0);
        chk("mrst_inj_pend", 64'(inj_pend), 64'd0);
        chk("mrst_inj_bad", 64'(inj_bad), 64'd0);
        chk("mrst_word_cnt", 64'(word_cnt), 64'd0);
        chk("mrst_inj_cnt", 64'(inj_cnt), 64'd0);
        #1;
        rst = 1'b0; s_tx_vld = 1'b0; flush = 1'b0; inj_en = 1'b0;
        exp_wcnt = 0;
        idle(12);
        drive(1'b1, vin[2], vexp[2], 4, 1'b1, 1'b0, 6'd0);
        idle(6);

        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
